// File: rtl/serial_word_packer_if.sv
// Serial-in / FIFO-write bundle for serial_word_packer.
// master: packer side (serial in, full in; wr_en/wr_data out). slave: the other side.
interface serial_word_packer_if #(
    parameter int K = 4
);
    logic         sin;
    logic         sin_valid;
    logic         full;
    logic         wr_en;
    logic [K-1:0] wr_data;

    modport master (
        input  sin,
        input  sin_valid,
        input  full,
        output wr_en,
        output wr_data
    );

    modport slave (
        output sin,
        output sin_valid,
        output full,
        input  wr_en,
        input  wr_data
    );
endinterface

// File: rtl/serial_word_packer.sv
// Packs an MSB-first serial stream into K-bit words for a FIFO write port.
// Ports: clk, rst (async, active-low), bus (sin/sin_valid/full in, wr_en/wr_data out),
// clr_ovr in, busy/overrun/words_sent out.
module serial_word_packer #(
    parameter int K  = 4,
    parameter int CW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_word_packer_if.master   bus,
    input  logic                   clr_ovr,
    output logic                   busy,
    output logic                   overrun,
    output logic [CW-1:0]          words_sent
);
    localparam int CNTW = $clog2(K);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(K - 1);

    logic [K-1:0]    sh_q, sh_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [K-1:0]    hold_q, hold_d;
    logic            hv_q, hv_d;
    logic            ovr_q, ovr_d;
    logic [CW-1:0]   ws_q, ws_d;

    logic         push;
    logic         complete;
    logic [K-1:0] word;

    assign push     = hv_q & ~bus.full;
    assign word     = {sh_q[K-2:0], bus.sin};
    assign complete = bus.sin_valid & (cnt_q == CNT_LAST);

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        hold_d = hold_q;
        hv_d   = hv_q;
        ovr_d  = ovr_q;
        ws_d   = ws_q;
        if (bus.sin_valid) begin
            sh_d  = word;
            cnt_d = complete ? '0 : cnt_q + 1'b1;
        end
        if (push) begin
            hv_d = 1'b0;
            ws_d = ws_q + 1'b1;
        end
        if (clr_ovr)
            ovr_d = 1'b0;
        if (complete) begin
            // The hold slot is free if empty or being pushed this edge.
            if (!hv_q || push) begin
                hold_d = word;
                hv_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            hold_q <= '0;
            hv_q   <= 1'b0;
            ovr_q  <= 1'b0;
            ws_q   <= '0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            hv_q   <= hv_d;
            ovr_q  <= ovr_d;
            ws_q   <= ws_d;
        end
    end

    assign bus.wr_en   = push;
    assign bus.wr_data = hold_q;
    assign busy        = (cnt_q != '0) | hv_q;
    assign overrun     = ovr_q;
    assign words_sent  = ws_q;
endmodule

// File: tb/tb_serial_word_packer.sv
// Self-checking bench for serial_word_packer (K=4, CW=2).
// Directed scenarios followed by randomized traffic against a queue-based model.
module tb_serial_word_packer;
    localparam int K  = 4;
    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic          clr_ovr;
    logic          busy;
    logic          overrun;
    logic [CW-1:0] words_sent;

    serial_word_packer_if #(.K(K)) bus ();

    serial_word_packer #(.K(K), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
        .clr_ovr    (clr_ovr),
        .busy       (busy),
        .overrun    (overrun),
        .words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit           bitq[$];
    logic [K-1:0] exp_q[$];
    int           m_hcnt = 0;
    int           m_ws   = 0;
    bit           m_ovr  = 1'b0;
    bit           exp_wr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: away from the active edge, compare the write port.
    always @(negedge clk) begin
        chk("wr_en", {31'd0, bus.wr_en}, {31'd0, exp_wr});
        if (bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_push", 32'd1, 32'd0);
            end else begin
                logic [K-1:0] e;
                e = exp_q.pop_front();
                chk("wr_data", {28'd0, bus.wr_data}, {28'd0, e});
            end
        end
    end

    function automatic void model_reset();
        bitq.delete();
        exp_q.delete();
        m_hcnt = 0;
        m_ws   = 0;
        m_ovr  = 1'b0;
        exp_wr = 1'b0;
    endfunction

    // Called just after a rising edge: check state, drive inputs for the
    // next edge, and predict what that edge does.
    task automatic cyc(input bit s, input bit v, input bit f, input bit c);
        bit           push, complete, drop;
        logic [K-1:0] w;
        chk("busy", {31'd0, busy},
            {31'd0, (bitq.size() != 0 || m_hcnt > 0)});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        chk("words_sent", {30'd0, words_sent}, m_ws);
        bus.sin       = s;
        bus.sin_valid = v;
        bus.full      = f;
        clr_ovr       = c;
        push     = (m_hcnt > 0) && !f;
        exp_wr   = push;
        complete = 1'b0;
        w        = '0;
        if (v) begin
            bitq.push_back(s);
            if (bitq.size() == K) begin
                int val;
                val = 0;
                for (int i = 0; i < K; i++)
                    val = val * 2 + int'(bitq[i]);
                w = val[K-1:0];
                bitq.delete();
                complete = 1'b1;
            end
        end
        drop = complete && (m_hcnt > 0) && !push;
        if (push) begin
            m_hcnt--;
            m_ws = (m_ws + 1) % (1 << CW);
        end
        if (complete && !drop) begin
            exp_q.push_back(w);
            m_hcnt++;
        end
        if (drop)
            m_ovr = 1'b1;
        else if (c)
            m_ovr = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [K-1:0] w, input bit f);
        for (int i = K - 1; i >= 0; i--)
            cyc(w[i], 1'b1, f, 1'b0);
    endtask

    task automatic idle(input int n, input bit f);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, f, 1'b0);
    endtask

    initial begin
        rst           = 1'b0;
        clr_ovr       = 1'b0;
        bus.sin       = 1'b0;
        bus.sin_valid = 1'b0;
        bus.full      = 1'b0;
        model_reset();
        #1;
        chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("rst_wr_data", {28'd0, bus.wr_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_words_sent", {30'd0, words_sent}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;

        // Single word, then back-to-back words
        send_word(4'b1011, 1'b0);
        idle(2, 1'b0);
        send_word(4'b1011, 1'b0);
        send_word(4'b0110, 1'b0);
        send_word(4'b1111, 1'b0);
        idle(2, 1'b0);

        // Back-pressure: held 3 cycles, then released
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        idle(2, 1'b0);

        // Overrun: two words complete while full
        send_word(4'b0001, 1'b1);
        send_word(4'b0010, 1'b1);
        idle(2, 1'b0);
        idle(2, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Asynchronous reset mid-word
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        bus.sin_valid = 1'b0;
        bus.full      = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("arst_words_sent", {30'd0, words_sent}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        send_word(4'b0101, 1'b0);
        idle(2, 1'b0);

        // Gapped bits inside words; wrap of words_sent
        for (int n = 0; n < 5; n++) begin
            logic [K-1:0] w;
            w = K'(n * 3 + 5);
            for (int i = K - 1; i >= 0; i--) begin
                cyc(w[i], 1'b1, 1'b0, 1'b0);
                if (i % 2 == 0)
                    idle(1 + n % 2, 1'b0);
            end
        end
        idle(2, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
        end

        // Drain and confirm nothing expected is left unpushed
        idle(4, 1'b0);
        chk("drain_exp_q", exp_q.size(), 32'd0);
        chk("drain_hold", m_hcnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_word_packer.md
# serial_word_packer

Serial-to-parallel front end for the word FIFO datapath. It collects a serial bit stream MSB-first into K-bit words and pushes each word into the FIFO write port with a valid/full handshake. A one-word holding register absorbs FIFO back-pressure. Overflow is reported as a sticky flag. Its counterpart is the FIFO's MSB-first serial read side.

## Interface
Parameters:
- K, 4, word width and bits per word; legal range K ≥ 2.
- CW, 8, width of the pushed-word counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- sin  in  1  serial data bit.
- sin_valid  in  1  sin is sampled on this edge when 1.
- full  in  1  FIFO full; blocks the write.
- clr_ovr  in  1  synchronous clear of overrun.
- wr_en  out  1  write strobe to the FIFO.
- wr_data  out  K  word to write.
- busy  out  1  partial word or held word present.
- overrun  out  1  sticky; a completed word was dropped.
- words_sent  out  CW  count of words accepted by the FIFO.

## Operation
- Registers: shift register sh[K-1:0], bit counter cnt (0..K-1, width clog2(K)), hold[K-1:0], hold_valid, overrun, words_sent.
- States are encoded by (cnt, hold_valid):
  - IDLE: cnt=0, !hold_valid.
  - COLLECT: cnt≠0, !hold_valid.
  - HOLD: hold_valid, with collection of the next word continuing in parallel.
- Sampling: on an edge with sin_valid=1, sh <= {sh[K-2:0], sin}. If cnt<K-1, cnt increments. Otherwise a word is completed: cnt <= 0, and the full word {sh[K-2:0], sin} is the candidate for hold. The first bit received ends up as the MSB.
- Handshake: wr_en = hold_valid & ~full (combinational); wr_data = hold. A push occurs on any edge where wr_en=1.
- Update of hold on each edge, depending on push and word completion:
  - Push, no completion: hold_valid <= 0.
  - Completion, no hold_valid: hold <= word, hold_valid <= 1.
  - Push and completion on the same edge: hold <= new word, hold_valid stays 1. No loss.
  - Completion while hold_valid=1 and no push: the new word is dropped, hold is unchanged, overrun <= 1.
- overrun stays set until clr_ovr=1 or reset. If clr_ovr and a drop occur on the same edge, the drop wins and overrun stays 1.
- words_sent increments by 1 per push and wraps modulo 2^CW.
- busy = (cnt≠0) | hold_valid.
- sin_valid=0 freezes sh and cnt. Gaps between bits are allowed, including inside a word.
- Width rules: hold and wr_data are exactly K bits. No sign handling; data is raw bits.

## Timing
- Reset (rst=0, asynchronous): sh=0, cnt=0, hold=0, hold_valid=0, overrun=0, words_sent=0. Outputs immediately: wr_en=0, wr_data=0, busy=0, overrun=0, words_sent=0.
- Reset mid-word or with a held word: partial and held data are discarded and not pushed. The first valid bit after rst deassertion starts a new word.
- Latency: wr_en rises in the cycle immediately after the edge that samples the K-th bit (if full=0). The FIFO captures the word on the next edge. Total is K sampling edges plus 1 edge to push.
- Sustained input of 1 bit/clk with full=0 never overruns: one push per K cycles.
- With full=1, a word can be held for up to K-1 additional bit samples. The next completion then overruns unless full has dropped by that edge.
- full is sampled combinationally each cycle. wr_en falls in the same cycle that full rises.

## Test plan
- K=4: send 1,0,1,1 on 4 consecutive edges with full=0 → wr_en=1 for exactly 1 cycle, wr_data=4'b1011, words_sent=1, busy=0 afterwards.
- Back-to-back: 3 words 1011, 0110, 1111 at 1 bit/clk → 3 single-cycle pushes, 4 cycles apart, in order, overrun=0, words_sent=3.
- Back-pressure: full=1 before word 1010 completes, held 3 cycles, then full=0 → wr_en=0 while full, push of 1010 on the first edge after release, no overrun.
- Overrun: full=1 held while 2 words (0001, 0010) complete → only 0001 is pushed after release, overrun=1 until clr_ovr pulse, then 0.
- Reset mid-word: 2 bits sent, rst pulsed low asynchronously between edges → busy=0 immediately. Then 0,1,0,1 → wr_data=4'b0101.
- Counter wrap with CW=2: 5 words pushed → words_sent sequence 1,2,3,0,1. Gapped sin_valid inside words does not alter the data.
